l2_cacheline_adapter: RTL and testbench
=======================================

Name: l2_cacheline_adapter

Overview:
- Downstream neighbour of the L2 cache datapath. Sits between the L2 and physical memory.
- Converts the L2's single-transfer 256-bit line interface into a 4-beat, 64-bit burst memory protocol, for both fills (reads) and writebacks (writes).
- Assembles incoming read beats into one line. Serialises a captured write line into beats.
- Signals the L2 controller with a one-cycle completion pulse.

Parameters:
- s_line, 256, cacheline width in bits
- s_burst, 64, burst beat width in bits
- s_offset, 5, line-offset bits zeroed in the memory address
- num_beats, s_line/s_burst (4), beats per line; counter width is clog2(num_beats)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- line_i  in  256  write line from L2 (pmem_wdata)
- line_o  out  256  assembled read line to L2 (pmem_rdata)
- address_i  in  32  line address from L2 (pmem_address)
- read_i  in  1  L2 fill request
- write_i  in  1  L2 writeback request
- resp_o  out  1  one-cycle completion pulse to L2
- burst_i  in  64  read beat from memory
- burst_o  out  64  write beat to memory
- address_o  out  32  burst address to memory
- read_o  out  1  memory read request
- write_o  out  1  memory write request
- resp_i  in  1  memory beat accept/valid

Behaviour:
- Single clock. Synchronous active-high reset. All state registers update on posedge clk.
- Reset values: state=IDLE, beat count=0, line/address registers=0, resp_o=0, read_o=0, write_o=0, line_o=0, burst_o=0, address_o=0.
- Reset mid-transaction: at the next edge, return to IDLE with count=0. read_o/write_o deassert the cycle after rst is sampled. The partial line is discarded; line_o is cleared.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - read_i=1: capture address_i, go to READ.
  - else write_i=1: capture address_i and line_i, go to WRITE.
  - Both asserted: read wins (illegal usage, but deterministic).
  - resp_i is ignored.
- address_o = {captured address[31:5], 5'b0}, constant for the whole transaction. It is driven in IDLE/DONE too.
- READ:
  - read_o=1.
  - Each cycle with resp_i=1: write burst_i into line register bits [64*count +: 64], then count++.
  - Beat 0 is the least significant 64 bits.
  - resp_i may have gaps; only cycles with resp_i=1 count.
  - On the resp_i cycle with count==num_beats-1: go to DONE and reset count to 0.
- WRITE:
  - write_o=1; burst_o = captured line[64*count +: 64] (combinational from count).
  - Each resp_i=1 cycle: count++.
  - After the 4th accepted beat: go to DONE and reset count to 0.
- DONE:
  - resp_o=1 for exactly this one cycle; read_o=write_o=0.
  - Unconditionally return to IDLE.
  - line_o holds the assembled line from DONE onward, until the next read's first beat or reset.
- Latency:
  - Request sampled at edge N; read_o/write_o high in cycle N+1.
  - With back-to-back resp_i, the 4 beats occur in cycles N+1..N+4, resp_o in N+5, IDLE in N+6.
- Upstream contract: the L2 controller deasserts read_i/write_i in the cycle after resp_o. Any request still high in IDLE starts a new transaction.
- read_i/write_i/address_i/line_i changes during READ/WRITE are ignored (captured values are used).
- Count wraps only via the explicit reset to 0; it never exceeds num_beats-1.

Test Plan:
- Reset, then idle for 5 cycles -> all outputs 0, no read_o/write_o.
- read_i=1, address_i=0x1234_5678; memory returns beats 0x1111…, 0x2222…, 0x3333…, 0x4444… on consecutive resp_i.
  - address_o=0x1234_5660.
  - read_o high for exactly 4 cycles.
  - resp_o pulses once, 5 cycles after the request edge.
  - line_o = {0x4444…,0x3333…,0x2222…,0x1111…}.
- write_i=1 with line_i = 256'h0123…CDEF (distinct beats); resp_i held high -> burst_o presents line_i[63:0], [127:64], [191:128], [255:192] in order; write_o high for 4 cycles; single resp_o pulse.
- Read with resp_i gaps (pattern 1,0,0,1,1,0,1) -> beats land only on resp_i=1 cycles; resp_o after the 4th accepted beat; line_o correct.
- rst asserted after 2 read beats -> IDLE next edge, read_o low, line_o=0, no resp_o. A subsequent clean read completes correctly.
- read_i and write_i asserted together -> READ performed, write_o never asserted. Back-to-back read then write with the request dropped the cycle after resp_o -> two independent resp_o pulses.

Source files
------------

// File: rtl/l2_cacheline_adapter.sv
// Bridges the L2's single-transfer 256-bit line port to a 4-beat 64-bit memory burst.
// Read beats are assembled into line_o; a captured write line is serialised onto burst_o.
module l2_cacheline_adapter #(
  parameter int s_line    = 256,
  parameter int s_burst   = 64,
  parameter int s_offset  = 5,
  parameter int num_beats = s_line / s_burst
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int CNT_W = (num_beats > 1) ? $clog2(num_beats) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(num_beats - 1);
  localparam logic [31:0] ADDR_MASK = ~((32'd1 << s_offset) - 32'd1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_count;
  logic [31:0]        r_addr;
  logic [s_line-1:0]  r_wline;
  logic [s_line-1:0]  r_rline;
  logic               r_read;
  logic               r_write;
  logic               r_resp;

  // Read and write lines are kept apart so a writeback never disturbs the last filled line.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_addr  <= '0;
      r_wline <= '0;
      r_rline <= '0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_resp  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_count <= '0;
          if (read_i) begin
            r_addr  <= address_i;
            r_read  <= 1'b1;
            r_state <= READ;
          end else if (write_i) begin
            r_addr  <= address_i;
            r_wline <= line_i;
            r_write <= 1'b1;
            r_state <= WRITE;
          end
        end
        READ: begin
          if (resp_i) begin
            r_rline[s_burst*int'(r_count) +: s_burst] <= burst_i;
            if (r_count == LAST_BEAT) begin
              r_count <= '0;
              r_read  <= 1'b0;
              r_resp  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_count <= r_count + 1'b1;
            end
          end
        end
        WRITE: begin
          if (resp_i) begin
            if (r_count == LAST_BEAT) begin
              r_count <= '0;
              r_write <= 1'b0;
              r_resp  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_count <= r_count + 1'b1;
            end
          end
        end
        DONE: begin
          r_resp  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_count <= '0;
          r_read  <= 1'b0;
          r_write <= 1'b0;
          r_resp  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign address_o = r_addr & ADDR_MASK;
  assign burst_o   = r_wline[s_burst*int'(r_count) +: s_burst];
  assign line_o    = r_rline;
  assign read_o    = r_read;
  assign write_o   = r_write;
  assign resp_o    = r_resp;

endmodule

// File: tb/tb_l2_cacheline_adapter.sv
// Directed bench for l2_cacheline_adapter: scoreboard queues hold expected lines/beats,
// a negedge monitor pops them as the DUT completes transactions or accepts write beats.
module tb_l2_cacheline_adapter;

  logic         clk;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  typedef struct {
    bit           isRead;
    logic [255:0] line;
    int           rdCyc;
    int           wrCyc;
  } txn_t;

  txn_t         txQ[$];
  logic [63:0]  beatQ[$];
  int           checks = 0;
  int           errors = 0;
  int           rdCycles = 0;
  int           wrCycles = 0;
  int           respSeen = 0;
  int           respExp = 0;
  logic [255:0] lastRead = '0;

  l2_cacheline_adapter dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: counts request cycles and retires scoreboard entries on beats and completions.
  always @(negedge clk) begin : monitor
    txn_t        t;
    logic [63:0] e;
    if (rst) begin
      rdCycles = 0;
      wrCycles = 0;
    end else begin
      if (read_o)  rdCycles++;
      if (write_o) wrCycles++;
      if (write_o && resp_i) begin
        checkOutput("beatq_nonempty", beatQ.size() != 0, 1);
        if (beatQ.size() != 0) begin
          e = beatQ.pop_front();
          checkOutput("burst_o", burst_o, e);
        end
      end
      if (resp_o) begin
        respSeen++;
        checkOutput("txq_nonempty", txQ.size() != 0, 1);
        if (txQ.size() != 0) begin
          t = txQ.pop_front();
          if (t.isRead) checkOutput("line_o", line_o, t.line);
          checkOutput("read_o_cycles", rdCycles, t.rdCyc);
          checkOutput("write_o_cycles", wrCycles, t.wrCyc);
        end
        rdCycles = 0;
        wrCycles = 0;
      end
    end
  end

  // Issues one request and plays the memory side with the given resp_i pattern (bit c = cycle c).
  task automatic applyStimulus(input bit rq, input bit wq, input logic [31:0] addr,
                               input logic [255:0] wline, input logic [255:0] memLine,
                               input logic [15:0] pat, input int patLen);
    txn_t t;
    int   beat = 0;
    t.isRead = rq;
    t.line   = memLine;
    t.rdCyc  = rq ? patLen : 0;
    t.wrCyc  = rq ? 0 : patLen;
    txQ.push_back(t);
    respExp++;
    if (!rq)
      for (int i = 0; i < 4; i++) beatQ.push_back(wline[64*i +: 64]);
    read_i    = rq;
    write_i   = wq;
    address_i = addr;
    line_i    = wline;
    tick();
    read_i    = 1'b0;
    write_i   = 1'b0;
    address_i = $urandom;
    line_i    = {8{$urandom}};
    for (int c = 0; c < patLen; c++) begin
      checkOutput("address_o", address_o, addr & 32'hFFFF_FFE0);
      checkOutput("rw_active", {read_o, write_o}, rq ? 2'b10 : 2'b01);
      checkOutput("resp_early", resp_o, 0);
      resp_i = pat[c];
      if (pat[c] && rq) burst_i = memLine[64*beat +: 64];
      else              burst_i = {$urandom, $urandom};
      if (pat[c]) beat++;
      tick();
    end
    resp_i = 1'b0;
    checkOutput("resp_o", resp_o, 1);
    checkOutput("rw_done", {read_o, write_o}, 2'b00);
    checkOutput("address_done", address_o, addr & 32'hFFFF_FFE0);
    tick();
    checkOutput("resp_pulse", resp_o, 0);
    if (rq) lastRead = memLine;
    checkOutput("line_o_hold", line_o, lastRead);
  endtask

  initial begin
    logic [255:0] memA, memB, memC, wLine;
    memA  = {64'h4444444444444444, 64'h3333333333333333,
             64'h2222222222222222, 64'h1111111111111111};
    memB  = {64'hDEADBEEF00000004, 64'hDEADBEEF00000003,
             64'hDEADBEEF00000002, 64'hDEADBEEF00000001};
    memC  = {64'hA5A5A5A5A5A5A5A5, 64'h5A5A5A5A5A5A5A5A,
             64'hFFFF0000FFFF0000, 64'h0000FFFF0000FFFF};
    wLine = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
             64'h0F1E2D3C4B5A6978, 64'h8796A5B4C3D2E1F0};

    rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    address_i = '0; line_i = '0; burst_i = '0;
    repeat (3) tick();
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      checkOutput("idle_ctrl", {read_o, write_o, resp_o}, 3'b000);
      checkOutput("idle_line_o", line_o, 0);
      checkOutput("idle_addr_burst", {address_o, burst_o}, 0);
      resp_i = 1'b1;
      tick();
    end
    resp_i = 1'b0;

    applyStimulus(1'b1, 1'b0, 32'h1234_5678, '0, memA, 16'h000F, 4);
    applyStimulus(1'b0, 1'b1, 32'hCAFE_F00D, wLine, '0, 16'h000F, 4);
    applyStimulus(1'b1, 1'b0, 32'h0000_103F, '0, memB, 16'h0059, 7);

    // Abort a read after two beats; nothing is queued since no completion may follow.
    read_i = 1'b1; address_i = 32'h8000_0040;
    tick();
    read_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      resp_i = 1'b1; burst_i = {$urandom, $urandom};
      tick();
    end
    resp_i = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    lastRead = '0;
    checkOutput("rst_read_o", read_o, 0);
    checkOutput("rst_line_o", line_o, 0);
    checkOutput("rst_resp_o", resp_o, 0);
    checkOutput("rst_address_o", address_o, 0);
    tick();
    checkOutput("rst_idle", {read_o, write_o, resp_o}, 3'b000);

    applyStimulus(1'b1, 1'b0, 32'h8000_0040, '0, memC, 16'h000F, 4);
    applyStimulus(1'b1, 1'b1, 32'h2468_ACE0, wLine, memA, 16'h001B, 5);
    applyStimulus(1'b1, 1'b0, 32'h1357_9BDF, '0, memB, 16'h000F, 4);
    applyStimulus(1'b0, 1'b1, 32'h1357_9BDF, ~wLine, '0, 16'h002D, 6);

    repeat (2) tick();
    checkOutput("resp_count", respSeen, respExp);
    checkOutput("txq_drained", txQ.size(), 0);
    checkOutput("beatq_drained", beatQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
